// File: rtl/alu_operand_entry.sv
// alu_operand_entry: debounced DE2 key/switch front end that sequences operand A, operand B and opcode entry
module alu_operand_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        CLOCK_50,
    input  logic        nRST,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    output logic [31:0] porta,
    output logic [31:0] portb,
    output logic [3:0]  aluop,
    output logic [1:0]  entry_state,
    output logic        op_valid
);
    typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, LOAD_OP = 2'd2, SHOW = 2'd3} state_t;

    logic [3:0]       key_s1, key_s2, stable, stable_d, press;
    logic [16:0]      sw_s1, sw_s2;
    logic [CNT_W-1:0] cnt [4];
    logic [31:0]      sw_ext, porta_n, portb_n;
    logic [3:0]       aluop_n;
    logic             op_valid_n;
    state_t           state, state_n;
    logic             unused_ok;

    assign unused_ok   = ^{press[2], SW[17]};
    assign sw_ext      = {{16{sw_s2[16] & sw_s2[15]}}, sw_s2[15:0]};
    assign entry_state = state;

    always_ff @(posedge CLOCK_50) begin
        if (!nRST) begin
            key_s1   <= '1;
            key_s2   <= '1;
            sw_s1    <= '1;
            sw_s2    <= '1;
            stable_d <= '1;
            press    <= '0;
        end else begin
            key_s1   <= KEY;
            key_s2   <= key_s1;
            sw_s1    <= SW[16:0];
            sw_s2    <= sw_s1;
            stable_d <= stable;
            press    <= stable_d & ~stable;
        end
    end

    // A key's stable level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < 4; i++) begin
            if (!nRST) begin
                cnt[i]    <= '0;
                stable[i] <= 1'b1;
            end else if (key_s2[i] == stable[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt[i]    <= '0;
                stable[i] <= key_s2[i];
            end else begin
                cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!nRST) begin
            state    <= LOAD_A;
            porta    <= '0;
            portb    <= '0;
            aluop    <= '0;
            op_valid <= 1'b0;
        end else begin
            state    <= state_n;
            porta    <= porta_n;
            portb    <= portb_n;
            aluop    <= aluop_n;
            op_valid <= op_valid_n;
        end
    end

    // Clear beats back beats enter; losing events in the same cycle are dropped
    always_comb begin
        state_n    = state;
        porta_n    = porta;
        portb_n    = portb;
        aluop_n    = aluop;
        op_valid_n = 1'b0;
        if (press[3]) begin
            state_n = LOAD_A;
            porta_n = '0;
            portb_n = '0;
            aluop_n = '0;
        end else if (press[1]) begin
            state_n = (state == LOAD_A) ? LOAD_A : state_t'(state - 2'd1);
        end else if (press[0]) begin
            state_n    = state_t'(state + 2'd1);
            porta_n    = (state == LOAD_A) ? sw_ext : porta;
            portb_n    = (state == LOAD_B) ? sw_ext : portb;
            aluop_n    = (state == LOAD_OP) ? sw_s2[3:0] : aluop;
            op_valid_n = (state == LOAD_OP);
        end
    end
endmodule

// File: doc/alu_operand_entry.md
Name: alu_operand_entry

Overview:
- Input-side front end for the ALU board build: converts raw DE2 pushbuttons and switches into registered ALU operands and opcode.
- Sits between the board pins (SW, KEY) and alu_if (porta, portb, aluop).
- Provides synchronisation, debouncing, press-edge detection and a 4-state entry sequencer. Replaces the level-latched operand capture used in the current board build.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key change (10 ms at 50 MHz); minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- nRST  in  1  synchronous active-low reset
- SW  in  18  raw switches: SW[15:0] operand value, SW[16] sign-extend enable, SW[3:0] opcode in LOAD_OP
- KEY  in  4  raw pushbuttons, active-low: KEY[0] enter, KEY[1] back, KEY[3] clear, KEY[2] unused
- porta  out  32  registered operand A to aluif.porta
- portb  out  32  registered operand B to aluif.portb
- aluop  out  4  registered opcode to aluif.aluop
- entry_state  out  2  current state: 0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 SHOW
- op_valid  out  1  one-cycle pulse when a complete operation has been entered

Behaviour:
- Reset (nRST low at a rising edge):
  - porta=0, portb=0, aluop=0, entry_state=LOAD_A, op_valid=0.
  - Sync flops=1, debounced key state=1 (released), counters=0, press events=0.
  - Reset mid-debounce discards the partial count.
- Sync: each KEY bit passes through 2 flops. SW is also 2-flop synced. SW is not debounced and is sampled only on an enter event.
- Debounce, per key:
  - While sync output equals stable state, the counter is held at 0.
  - While they differ, the counter increments each cycle.
  - When the counter is at DEBOUNCE_CYCLES-1 and they still differ, stable takes the sync value on the next edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count and causes no change.
- Press event: registered one-cycle pulse on stable 1->0. Release (0->1) produces no event. Holding a key gives exactly one event.
- Latency:
  - Raw key first low before edge 0.
  - sync2 is low after edge 1.
  - Stable flips at edge DEBOUNCE_CYCLES+1.
  - Event is high after edge DEBOUNCE_CYCLES+2.
  - FSM/register update occurs at edge DEBOUNCE_CYCLES+3.
- Extension rule for the captured value V:
  - If SW[16]=1: {{16{V[15]}}, V} (sign-extend).
  - Else: {16'h0, V} (zero-extend).
- FSM transitions on enter event:
  - LOAD_A: porta <= ext(SW[15:0]); go to LOAD_B.
  - LOAD_B: portb <= ext(SW[15:0]); go to LOAD_OP.
  - LOAD_OP: aluop <= SW[3:0]; op_valid=1 for exactly the next cycle; go to SHOW.
  - SHOW: go to LOAD_A. All registers are retained until overwritten.
- Back event: go to the previous state (LOAD_B->LOAD_A, LOAD_OP->LOAD_B, SHOW->LOAD_OP). No register changes. In LOAD_A, back has no effect.
- Clear event: from any state, porta=portb=0, aluop=0, go to LOAD_A, op_valid=0.
- Simultaneous events in the same cycle: priority is clear > back > enter. Lower-priority events that cycle are dropped.
- Outputs are stable between events. Only enter in LOAD_OP asserts op_valid.
- No combinational path from SW/KEY to any output.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then hold nRST high with keys released -> porta=0, portb=0, aluop=0, entry_state=0, op_valid never high.
- SW=18'h0_1234, KEY[0] low from before edge 0 for 10 cycles -> porta=32'h0000_1234 and entry_state=1 at edge 7; exactly one update while held.
- Full entry with SW[16]=1:
  - A=16'h8001 -> porta=32'hFFFF_8001.
  - B=16'h0002 -> portb=32'h0000_0002.
  - Op SW[3:0]=4'h3 -> aluop=3, op_valid high exactly 1 cycle, entry_state=3.
- KEY[0] glitch low for 3 cycles, then high -> no state change. Repeated bounce (low 2 / high 1 ×5, then low steady) -> exactly one enter event.
- In LOAD_OP, press back -> state 1, portb unchanged. In LOAD_A, back -> stays 0.
- In SHOW with porta=32'h1234, KEY[3] and KEY[0] pressed on the same cycle -> all outputs 0, entry_state=0 (clear wins). Assert nRST mid-debounce -> no event after release of reset.
